// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the three-port memory arbiter.
// Requesters hold req (level) until done; gnt marks acceptance, done marks completion.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [2:0]          req;
    logic [2:0]          wr;
    logic [3*ADDR_W-1:0] addr;
    logic [3*DATA_W-1:0] wdata;
    logic [2:0]          gnt;
    logic [2:0]          done;
    logic [DATA_W-1:0]   rdata;
    logic                busy;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                mem_nrd;
    logic                mem_nwr;
    logic [DATA_W-1:0]   mem_rdata;

    modport slave (
        input  req, wr, addr, wdata, mem_rdata,
        output gnt, done, rdata, busy, mem_addr, mem_wdata, mem_nrd, mem_nwr
    );

    modport master (
        output req, wr, addr, wdata, mem_rdata,
        input  gnt, done, rdata, busy, mem_addr, mem_wdata, mem_nrd, mem_nwr
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fixed-priority (DBG > LS > IF) arbiter for one single-port memory, with an IF
// starvation guard and programmable wait states per access.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int WAIT_STATES  = 1,
    parameter int STARVE_LIMIT = 4,
    localparam int SW          = $clog2(STARVE_LIMIT + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_port_arbiter_if.slave    bus,
    output logic [1:0]           dbg_state,
    output logic [SW-1:0]        dbg_starve_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t              state;
    logic [1:0]          owner;
    logic                own_wr;
    logic [3:0]          wcnt;
    logic [SW-1:0]       starve_cnt;

    logic [1:0]          win;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_wdata;

    // IF is promoted over DBG/LS once it has been passed over STARVE_LIMIT times.
    always_comb begin
        if (bus.req[0] && starve_cnt == SW'(STARVE_LIMIT)) win = 2'd0;
        else if (bus.req[2])                               win = 2'd2;
        else if (bus.req[1])                               win = 2'd1;
        else                                               win = 2'd0;
    end

    always_comb begin
        win_addr  = bus.addr[0 +: ADDR_W];
        win_wdata = bus.wdata[0 +: DATA_W];
        case (win)
            2'd1: begin
                win_addr  = bus.addr[ADDR_W +: ADDR_W];
                win_wdata = bus.wdata[DATA_W +: DATA_W];
            end
            2'd2: begin
                win_addr  = bus.addr[2*ADDR_W +: ADDR_W];
                win_wdata = bus.wdata[2*DATA_W +: DATA_W];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            owner         <= 2'd0;
            own_wr        <= 1'b0;
            wcnt          <= 4'd0;
            starve_cnt    <= '0;
            bus.gnt       <= 3'b000;
            bus.done      <= 3'b000;
            bus.busy      <= 1'b0;
            bus.rdata     <= '0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_nrd   <= 1'b1;
            bus.mem_nwr   <= 1'b1;
        end else begin
            bus.gnt  <= 3'b000;
            bus.done <= 3'b000;
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        owner         <= win;
                        own_wr        <= bus.wr[win];
                        bus.mem_addr  <= win_addr;
                        bus.mem_wdata <= win_wdata;
                        bus.mem_nrd   <= bus.wr[win];
                        bus.mem_nwr   <= ~bus.wr[win];
                        bus.gnt       <= 3'b001 << win;
                        bus.busy      <= 1'b1;
                        wcnt          <= 4'(WAIT_STATES);
                        state         <= ACCESS;
                        if (win == 2'd0 || !bus.req[0])
                            starve_cnt <= '0;
                        else if (starve_cnt != SW'(STARVE_LIMIT))
                            starve_cnt <= starve_cnt + 1'b1;
                    end
                end
                ACCESS: begin
                    if (wcnt != 4'd0) begin
                        wcnt <= wcnt - 1'b1;
                    end else begin
                        if (!own_wr) bus.rdata <= bus.mem_rdata;
                        bus.mem_nrd <= 1'b1;
                        bus.mem_nwr <= 1'b1;
                        bus.done    <= 3'b001 << owner;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dbg_state      = state;
    assign dbg_starve_cnt = starve_cnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a timeline model of each access is compared
// against the DUT every cycle, plus literal checks of latency, order and data.
module tb_mem_port_arbiter;

    localparam int WS    = 1;
    localparam int LIMIT = 4;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;
    logic [2:0] dbg_starve;

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .WAIT_STATES(WS), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .dbg_state      (dbg_state),
        .dbg_starve_cnt (dbg_starve)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // memory contents as a pure function of the address
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEADBEEF;
        return a * 32'h01010101 + 32'h5;
    endfunction

    assign bus.mem_rdata = mem_fn(bus.mem_addr);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // model: an access is a timeline t=0..WS+1 counted from the acceptance edge
    bit          m_busy;
    int          m_t;
    int          m_owner;
    bit          m_wr;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    int          m_starve;
    int          m_win;

    function automatic int pick(input logic [2:0] r, input int st);
        if (r[0] && st == LIMIT) return 0;
        for (int i = 2; i >= 0; i--) if (r[i]) return i;
        return 0;
    endfunction

    always_comb m_win = pick(bus.req, m_starve);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy   <= 0;
            m_t      <= 0;
            m_owner  <= 0;
            m_wr     <= 0;
            m_addr   <= '0;
            m_wdata  <= '0;
            m_rdata  <= '0;
            m_starve <= 0;
        end else if (m_busy) begin
            if (m_t == WS + 1) m_busy <= 0;
            else               m_t    <= m_t + 1;
            if (m_t == WS && !m_wr) m_rdata <= mem_fn(m_addr);
        end else if (bus.req != 3'b000) begin
            m_busy   <= 1;
            m_t      <= 0;
            m_owner  <= m_win;
            m_wr     <= bus.wr[m_win];
            m_addr   <= bus.addr[m_win*32 +: 32];
            m_wdata  <= bus.wdata[m_win*32 +: 32];
            m_starve <= (m_win == 0 || !bus.req[0]) ? 0 :
                        (m_starve < LIMIT ? m_starve + 1 : LIMIT);
        end
    end

    // scoreboard for grant order
    logic [2:0] exp_q[$];
    bit         order_on = 0;

    logic [2:0] exp_gnt, exp_done;
    bit         strobe_win;

    initial begin
        forever begin
            @(negedge clk);
            exp_gnt    = (m_busy && m_t == 0) ? 3'(1 << m_owner) : 3'b000;
            exp_done   = (m_busy && m_t == WS + 1) ? 3'(1 << m_owner) : 3'b000;
            strobe_win = m_busy && (m_t <= WS);
            check("gnt", bus.gnt, exp_gnt);
            check("done", bus.done, exp_done);
            check("busy", bus.busy, m_busy);
            check("mem_nrd", bus.mem_nrd, !(strobe_win && !m_wr));
            check("mem_nwr", bus.mem_nwr, !(strobe_win && m_wr));
            check("rdata", bus.rdata, m_rdata);
            check("starve_cnt", dbg_starve, m_starve);
            if (strobe_win) begin
                check("mem_addr", bus.mem_addr, m_addr);
                if (m_wr) check("mem_wdata", bus.mem_wdata, m_wdata);
            end
            if (order_on && bus.gnt != 3'b000)
                check("gnt_order", bus.gnt, (exp_q.size() != 0) ? exp_q.pop_front() : 3'b000);
        end
    end

    // driver: one access from requester idx, measured from its grant to its done
    task automatic single_access(input int idx, input logic w, input logic [31:0] a,
                                 input logic [31:0] d, output int lat, output int nrd_low,
                                 output int nwr_low, output logic [2:0] done_v,
                                 output logic [31:0] rd_v, output logic [31:0] wd_v);
        bit started;
        lat = 0; nrd_low = 0; nwr_low = 0; done_v = '0; rd_v = '0; wd_v = '0;
        started = 0;
        bus.wr[idx] = w;
        bus.addr[idx*32 +: 32]  = a;
        bus.wdata[idx*32 +: 32] = d;
        bus.req[idx] = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk); #1;
            if (bus.gnt[idx]) started = 1;
            if (started) begin
                if (!bus.mem_nrd) nrd_low++;
                if (!bus.mem_nwr) begin
                    nwr_low++;
                    wd_v = bus.mem_wdata;
                end
                if (bus.gnt[idx]) begin
                    // scramble sampled inputs after acceptance; they must be ignored
                    bus.addr[idx*32 +: 32]  = ~a;
                    bus.wdata[idx*32 +: 32] = ~d;
                    bus.wr[idx] = ~w;
                end
                if (bus.done != 3'b000) begin
                    done_v = bus.done;
                    rd_v   = bus.rdata;
                    bus.req[idx] = 1'b0;
                    break;
                end
                lat++;
            end
        end
        check("access_completed", done_v != 3'b000, 1'b1);
        bus.req[idx] = 1'b0;
    endtask

    int          lat, nrd_low, nwr_low, g;
    logic [2:0]  done_v;
    logic [31:0] rd_v, wd_v, prev_rd;
    bit          seen;

    initial begin
        rst_n     = 1'b0;
        bus.req   = '0;
        bus.wr    = '0;
        bus.addr  = '0;
        bus.wdata = '0;

        // 1: reset held with random requests
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            bus.req = 3'($urandom_range(0, 7));
            bus.wr  = 3'($urandom_range(0, 7));
            @(negedge clk); #1;
            check("rst_idle", {bus.gnt, bus.done, bus.busy, bus.mem_nrd, bus.mem_nwr}, 9'b000000011);
        end
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_rdata", bus.rdata, 32'h0);
        bus.req = '0;
        bus.wr  = '0;
        rst_n   = 1'b1;
        repeat (2) @(negedge clk);
        #1;

        // 2: IF read
        single_access(0, 1'b0, 32'h10, 32'h0, lat, nrd_low, nwr_low, done_v, rd_v, wd_v);
        check("t2_latency", lat, 2);
        check("t2_nrd_cycles", nrd_low, 2);
        check("t2_nwr_cycles", nwr_low, 0);
        check("t2_done", done_v, 3'b001);
        check("t2_rdata", rd_v, 32'hDEADBEEF);

        // 5: LS write
        prev_rd = bus.rdata;
        single_access(1, 1'b1, 32'h20, 32'h1234, lat, nrd_low, nwr_low, done_v, rd_v, wd_v);
        check("t5_nwr_cycles", nwr_low, WS + 1);
        check("t5_nrd_cycles", nrd_low, 0);
        check("t5_wdata", wd_v, 32'h1234);
        check("t5_done", done_v, 3'b010);
        check("t5_rdata_held", rd_v, prev_rd);

        // 3: all three request, each leaves after its done
        repeat (2) @(negedge clk);
        #1;
        exp_q    = {3'b100, 3'b010, 3'b001};
        order_on = 1;
        bus.wr   = 3'b000;
        bus.addr = {32'h50, 32'h40, 32'h30};
        bus.req  = 3'b111;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk); #1;
            if (bus.done != 3'b000) bus.req = bus.req & ~bus.done;
            if (bus.req == 3'b000 && !bus.busy) break;
        end
        check("t3_order_drained", exp_q.size(), 0);
        check("t3_rdata_last_if", bus.rdata, mem_fn(32'h30));

        // 4: starvation guard
        repeat (2) @(negedge clk);
        #1;
        exp_q = {3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b100};
        g = 0;
        bus.req = 3'b111;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk); #1;
            if (bus.gnt != 3'b000) begin
                g++;
                if (g == 4) check("t4_starve_at_limit", dbg_starve, 3'd4);
                if (g == 5) check("t4_starve_cleared", dbg_starve, 3'd0);
                if (g == 6) break;
            end
        end
        check("t4_grants", g, 6);
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); #1;
            if (bus.done != 3'b000) begin
                seen = 1;
                break;
            end
        end
        check("t4_last_done", seen, 1'b1);
        bus.req = 3'b000;
        repeat (3) @(negedge clk);
        #1;
        order_on = 0;
        check("t4_order_drained", exp_q.size(), 0);

        // 6: reset in the middle of an access
        bus.wr[0] = 1'b0;
        bus.addr[31:0] = 32'h10;
        bus.req[0] = 1'b1;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); #1;
            if (bus.gnt[0]) begin
                seen = 1;
                break;
            end
        end
        check("t6_gnt_seen", seen, 1'b1);
        bus.req[0] = 1'b0;
        @(negedge clk); #1;
        check("t6_mid_nrd", bus.mem_nrd, 1'b0);
        rst_n = 1'b0;
        #1;
        check("t6_rst_strobes", {bus.mem_nrd, bus.mem_nwr, bus.busy}, 3'b110);
        seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            if (bus.done != 3'b000) seen = 1;
        end
        check("t6_no_done", seen, 1'b0);
        rst_n = 1'b1;
        @(negedge clk); #1;
        check("t6_starve_cold", dbg_starve, 3'd0);
        single_access(0, 1'b0, 32'h10, 32'h0, lat, nrd_low, nwr_low, done_v, rd_v, wd_v);
        check("t6_latency", lat, 2);
        check("t6_nrd_cycles", nrd_low, 2);
        check("t6_rdata", rd_v, 32'hDEADBEEF);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
